// File: rtl/proc_mem_arb_pkg.sv
// Shared types and constants for the processor instruction/data memory arbiter.
package proc_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    // Starve count width; holds STARVE_MAX values 1..15.
    localparam int STARVE_W = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next value: hold at all-ones once reached.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/proc_mem_arb.sv
// Arbiter sharing one single-ported, variable-latency memory between the
// instruction-fetch port (I) and the data port (D). One outstanding
// transaction at a time; D has priority unless I has been starved for
// STARVE_MAX consecutive D grants.
// Handshake: a request transfers in a cycle where its val and rdy are both
// high; requesters hold val and fields stable until rdy; rdy is only raised
// in IDLE when the memory's memreq_rdy is high. Responses are one-cycle pulses.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module proc_mem_arb
    import proc_mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    output logic        imemreq_rdy,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    output logic [31:0] imemresp_data,
    input  logic        dmemreq_val,
    output logic        dmemreq_rdy,
    input  logic        dmemreq_type,
    input  logic [31:0] dmemreq_addr,
    input  logic [31:0] dmemreq_wdata,
    output logic        dmemresp_val,
    output logic [31:0] dmemresp_rdata,
    output logic        memreq_val,
    input  logic        memreq_rdy,
    output logic        memreq_type,
    output logic [31:0] memreq_addr,
    output logic [31:0] memreq_wdata,
    input  logic        memresp_val,
    input  logic [31:0] memresp_data,
    output logic [31:0] stat_igrant,
    output logic [31:0] stat_dgrant,
    output logic [31:0] stat_conflict,
    output state_e      dbg_state_o
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_e              state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                i_wins;

    // I wins only when D is absent or I has hit the starvation limit.
    assign i_wins = imemreq_val && (!dmemreq_val || (starve_q == STARVE_LIM));

    // Next-state, grant, starve-count and output steering.
    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        imemreq_rdy    = 1'b0;
        dmemreq_rdy    = 1'b0;
        imemresp_val   = 1'b0;
        imemresp_data  = '0;
        dmemresp_val   = 1'b0;
        dmemresp_rdata = '0;
        memreq_val     = 1'b0;
        memreq_type    = MEMREQ_READ;
        memreq_addr    = '0;
        memreq_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (i_wins) begin
                    memreq_val  = 1'b1;
                    memreq_type = MEMREQ_READ;
                    memreq_addr = imemreq_addr;
                    if (memreq_rdy) begin
                        imemreq_rdy = 1'b1;
                        starve_d    = '0;
                        state_d     = BUSY_I;
                    end
                end else if (dmemreq_val) begin
                    memreq_val   = 1'b1;
                    memreq_type  = dmemreq_type;
                    memreq_addr  = dmemreq_addr;
                    memreq_wdata = dmemreq_wdata;
                    if (memreq_rdy) begin
                        dmemreq_rdy = 1'b1;
                        state_d     = BUSY_D;
                        if (!imemreq_val) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_LIM) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end
                end
            end
            BUSY_I: begin
                if (memresp_val) begin
                    imemresp_val  = 1'b1;
                    imemresp_data = memresp_data;
                    state_d       = IDLE;
                end
            end
            BUSY_D: begin
                if (memresp_val) begin
                    dmemresp_val   = 1'b1;
                    dmemresp_rdata = memresp_data;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and starve-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign dbg_state_o = state_q;

`ifdef MEM_ARB_STATS_EN
    logic conflict;
    assign conflict = (state_q == IDLE) && imemreq_val && dmemreq_val;

    sat_counter #(.W(32)) u_stat_igrant (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (imemreq_rdy),
        .cnt_o (stat_igrant)
    );

    sat_counter #(.W(32)) u_stat_dgrant (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (dmemreq_rdy),
        .cnt_o (stat_dgrant)
    );

    sat_counter #(.W(32)) u_stat_conflict (
        .clk   (clk),
        .clr_i (rst),
        .en_i  (conflict),
        .cnt_o (stat_conflict)
    );
`else
    assign stat_igrant   = '0;
    assign stat_dgrant   = '0;
    assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_proc_mem_arb.sv
// Directed bench for proc_mem_arb: fetch, collision, starvation,
// backpressure, reset mid-transaction and statistics.
module tb_proc_mem_arb;
    import proc_mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic [31:0] imemresp_data;
    logic        dmemreq_val;
    logic        dmemreq_rdy;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic        dmemresp_val;
    logic [31:0] dmemresp_rdata;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_wdata;
    logic        memresp_val;
    logic [31:0] memresp_data;
    logic [31:0] stat_igrant;
    logic [31:0] stat_dgrant;
    logic [31:0] stat_conflict;
    state_e      dbg_state;

    int errors = 0;
    int checks = 0;

    proc_mem_arb #(.STARVE_MAX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .imemreq_val    (imemreq_val),
        .imemreq_rdy    (imemreq_rdy),
        .imemreq_addr   (imemreq_addr),
        .imemresp_val   (imemresp_val),
        .imemresp_data  (imemresp_data),
        .dmemreq_val    (dmemreq_val),
        .dmemreq_rdy    (dmemreq_rdy),
        .dmemreq_type   (dmemreq_type),
        .dmemreq_addr   (dmemreq_addr),
        .dmemreq_wdata  (dmemreq_wdata),
        .dmemresp_val   (dmemresp_val),
        .dmemresp_rdata (dmemresp_rdata),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memreq_type    (memreq_type),
        .memreq_addr    (memreq_addr),
        .memreq_wdata   (memreq_wdata),
        .memresp_val    (memresp_val),
        .memresp_data   (memresp_data),
        .stat_igrant    (stat_igrant),
        .stat_dgrant    (stat_dgrant),
        .stat_conflict  (stat_conflict),
        .dbg_state_o    (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1 ns later,
    // well away from the rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imemreq_val   = 1'b0;
        imemreq_addr  = '0;
        dmemreq_val   = 1'b0;
        dmemreq_type  = 1'b0;
        dmemreq_addr  = '0;
        dmemreq_wdata = '0;
        memreq_rdy    = 1'b0;
        memresp_val   = 1'b0;
        memresp_data  = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // ---------------- reset state ----------------
        next_cycle();
        next_cycle();
        #1;
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_memreq_val", 32'(memreq_val), 32'd0);
        chk("rst_irdy", 32'(imemreq_rdy), 32'd0);
        chk("rst_drdy", 32'(dmemreq_rdy), 32'd0);
        chk("rst_iresp", 32'(imemresp_val), 32'd0);
        chk("rst_dresp", 32'(dmemresp_val), 32'd0);
        chk("rst_addr", memreq_addr, 32'd0);
        chk("rst_stat_i", stat_igrant, 32'd0);
        rst = 1'b0;

        // ---------------- fetch only, latency 2 ----------------
        next_cycle();
        imemreq_val = 1'b1; imemreq_addr = 32'h200; memreq_rdy = 1'b1;
        #1;
        chk("f_irdy", 32'(imemreq_rdy), 32'd1);
        chk("f_memreq_val", 32'(memreq_val), 32'd1);
        chk("f_addr", memreq_addr, 32'h200);
        chk("f_type", 32'(memreq_type), 32'd0);
        chk("f_drdy", 32'(dmemreq_rdy), 32'd0);
        next_cycle();
        imemreq_val = 1'b0; imemreq_addr = '0;
        #1;
        chk("f_busy_state", 32'(dbg_state), 32'(BUSY_I));
        chk("f_busy_memreq_val", 32'(memreq_val), 32'd0);
        chk("f_busy_iresp", 32'(imemresp_val), 32'd0);
        next_cycle();
        memresp_val = 1'b1; memresp_data = 32'h00A00093;
        imemreq_val = 1'b1; imemreq_addr = 32'h204;
        #1;
        chk("f_iresp_val", 32'(imemresp_val), 32'd1);
        chk("f_iresp_data", imemresp_data, 32'h00A00093);
        chk("f_dresp_val", 32'(dmemresp_val), 32'd0);
        chk("f_dresp_data", dmemresp_rdata, 32'd0);
        chk("f_no_accept_in_resp", 32'(imemreq_rdy), 32'd0);
        next_cycle();
        memresp_val = 1'b0; memresp_data = '0;
        #1;
        chk("f_next_accept", 32'(imemreq_rdy), 32'd1);
        chk("f_next_addr", memreq_addr, 32'h204);
        next_cycle();
        imemreq_val = 1'b0; imemreq_addr = '0;
        memresp_val = 1'b1; memresp_data = 32'h11;
        #1;
        chk("f2_iresp_data", imemresp_data, 32'h11);
        next_cycle();
        memresp_val = 1'b0; memresp_data = '0;

        // ---------------- collision ----------------
        do_reset();
        imemreq_val = 1'b1; imemreq_addr = 32'h300;
        dmemreq_val = 1'b1; dmemreq_type = 1'b1;
        dmemreq_addr = 32'h1000; dmemreq_wdata = 32'hDEADBEEF;
        memreq_rdy = 1'b1;
        #1;
        chk("c_drdy", 32'(dmemreq_rdy), 32'd1);
        chk("c_irdy", 32'(imemreq_rdy), 32'd0);
        chk("c_type", 32'(memreq_type), 32'd1);
        chk("c_addr", memreq_addr, 32'h1000);
        chk("c_wdata", memreq_wdata, 32'hDEADBEEF);
        next_cycle();
        dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = '0; dmemreq_wdata = '0;
        memresp_val = 1'b1; memresp_data = 32'h0;
        #1;
        chk("c_dack", 32'(dmemresp_val), 32'd1);
        chk("c_iresp_quiet", 32'(imemresp_val), 32'd0);
        chk("c_irdy_in_resp", 32'(imemreq_rdy), 32'd0);
        next_cycle();
        memresp_val = 1'b0;
        #1;
        chk("c_i_accept", 32'(imemreq_rdy), 32'd1);
        chk("c_i_addr", memreq_addr, 32'h300);
        chk("c_i_type", 32'(memreq_type), 32'd0);
        next_cycle();
        imemreq_val = 1'b0; imemreq_addr = '0;
        memresp_val = 1'b1; memresp_data = 32'h22;
        #1;
        chk("c_iresp_data", imemresp_data, 32'h22);
        next_cycle();
        memresp_val = 1'b0; memresp_data = '0;
        #1;
`ifdef MEM_ARB_STATS_EN
        chk("stat_dgrant", stat_dgrant, 32'd1);
        chk("stat_igrant", stat_igrant, 32'd1);
        chk("stat_conflict", stat_conflict, 32'd1);
`else
        chk("stat_dgrant_tied", stat_dgrant, 32'd0);
        chk("stat_igrant_tied", stat_igrant, 32'd0);
        chk("stat_conflict_tied", stat_conflict, 32'd0);
`endif

        // ---------------- starvation, STARVE_MAX = 4 ----------------
        do_reset();
        imemreq_val = 1'b1; imemreq_addr = 32'h400;
        dmemreq_val = 1'b1; dmemreq_type = 1'b0;
        memreq_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dmemreq_addr = 32'h2000 + 32'(k * 4);
            memresp_val = 1'b0;
            #1;
            chk($sformatf("s_d%0d_grant", k), 32'(dmemreq_rdy), 32'd1);
            chk($sformatf("s_d%0d_irdy", k), 32'(imemreq_rdy), 32'd0);
            chk($sformatf("s_d%0d_addr", k), memreq_addr, 32'h2000 + 32'(k * 4));
            next_cycle();
            memresp_val = 1'b1; memresp_data = 32'h100 + 32'(k);
            #1;
            chk($sformatf("s_d%0d_resp", k), dmemresp_rdata, 32'h100 + 32'(k));
            next_cycle();
        end
        memresp_val = 1'b0; memresp_data = '0;
        #1;
        chk("s_i_forced", 32'(imemreq_rdy), 32'd1);
        chk("s_d_blocked", 32'(dmemreq_rdy), 32'd0);
        chk("s_i_addr", memreq_addr, 32'h400);
        next_cycle();
        imemreq_val = 1'b0; imemreq_addr = '0;
        memresp_val = 1'b1; memresp_data = 32'h44;
        #1;
        chk("s_iresp_val", 32'(imemresp_val), 32'd1);
        chk("s_dresp_quiet", 32'(dmemresp_val), 32'd0);
        next_cycle();
        memresp_val = 1'b0; memresp_data = '0;
        dmemreq_addr = 32'h2100;
        #1;
        chk("s_d_resume", 32'(dmemreq_rdy), 32'd1);
        next_cycle();
        dmemreq_val = 1'b0; dmemreq_addr = '0;
        memresp_val = 1'b1; memresp_data = 32'h55;
        next_cycle();
        memresp_val = 1'b0; memresp_data = '0;

        // ---------------- backpressure ----------------
        dmemreq_val = 1'b1; dmemreq_addr = 32'h3000; memreq_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_drdy", k), 32'(dmemreq_rdy), 32'd0);
            chk($sformatf("bp%0d_memreq_val", k), 32'(memreq_val), 32'd1);
            chk($sformatf("bp%0d_state", k), 32'(dbg_state), 32'(IDLE));
            next_cycle();
        end
        memreq_rdy = 1'b1;
        #1;
        chk("bp_accept", 32'(dmemreq_rdy), 32'd1);
        chk("bp_addr", memreq_addr, 32'h3000);

        // ---------------- reset while BUSY_D ----------------
        next_cycle();
        dmemreq_val = 1'b0; dmemreq_addr = '0; memreq_rdy = 1'b0;
        #1;
        chk("r_busy_d", 32'(dbg_state), 32'(BUSY_D));
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        memresp_val = 1'b1; memresp_data = 32'h66;
        #1;
        chk("r_dresp_dropped", 32'(dmemresp_val), 32'd0);
        chk("r_iresp_dropped", 32'(imemresp_val), 32'd0);
        chk("r_ddata_zero", dmemresp_rdata, 32'd0);
        chk("r_state_idle", 32'(dbg_state), 32'(IDLE));
        next_cycle();
        memresp_val = 1'b0; memresp_data = '0;
        #1;
        chk("r_still_idle", 32'(dbg_state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_mem_arb.md
# proc_mem_arb

Arbiter that shares a single-ported, variable-latency memory between the pipelined processor's instruction-fetch port and its data port. It sits between the processor datapath/control and the memory. Each requester uses a val/rdy request handshake and receives a one-cycle response pulse. The processor control unit uses the rdy/resp signals to stall its F and M stages.

## Interface
- STARVE_MAX, default 4: consecutive D grants allowed while I is pending before I is forced a grant (range 1..15)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- imemreq_val  in  1  fetch request valid; held until accepted
- imemreq_rdy  out  1  fetch request accepted this cycle
- imemreq_addr  in  32  fetch address
- imemresp_val  out  1  fetch response pulse
- imemresp_data  out  32  fetch data, valid with imemresp_val
- dmemreq_val  in  1  data request valid; held until accepted
- dmemreq_rdy  out  1  data request accepted this cycle
- dmemreq_type  in  1  0 = read, 1 = write
- dmemreq_addr  in  32  data address
- dmemreq_wdata  in  32  store data
- dmemresp_val  out  1  data response pulse; read data or write ack
- dmemresp_rdata  out  32  load data, valid with dmemresp_val
- memreq_val  out  1  memory request valid
- memreq_rdy  in  1  memory accepts request
- memreq_type, memreq_addr, memreq_wdata  out  1/32/32  forwarded from the granted requester; I is always read
- memresp_val  in  1  memory response
- memresp_data  in  32  memory response data
- stat_igrant, stat_dgrant, stat_conflict  out  32 each  statistics (see Configuration)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset: IDLE, starve count 0.
- IDLE, grant selection:
  - D wins over I, unless I is pending and starve count == STARVE_MAX; then I wins.
  - memreq_val = granted requester's val. memreq_* fields come from the granted requester.
- IDLE, on memreq_val & memreq_rdy:
  - Assert the granted port's req_rdy (combinational). Go to BUSY_I or BUSY_D.
- Starve count:
  - D accepted while imemreq_val = 1: count increments, saturating at STARVE_MAX.
  - Any I accept: count clears.
  - D accepted while I is idle: count clears.
- BUSY_x: memreq_val = 0; both req_rdy = 0.
- BUSY_x, on memresp_val: assert x's resp_val with memresp_data passed through, then return to IDLE.
- Non-owner resp_val is always 0. Resp data is 0 when its val = 0.
- memresp_val in IDLE (stale response after reset) is ignored.
- At most one outstanding memory transaction.
- Requests arriving during BUSY are held by the requester and arbitrated in the first IDLE cycle.

## Timing
- All outputs are 0 during and after reset until a request arrives.
- Request path is combinational: accept occurs in the same cycle memreq_rdy is seen in IDLE.
- Response path is combinational from memresp_val. The arbiter adds 0 cycles of latency.
- Exactly one IDLE cycle separates a response from the next accept. Peak throughput is 1 transaction per 2 cycles with a 1-cycle memory.
- memresp_val in the same cycle as new requests: the response is delivered; the new request is accepted no earlier than the next cycle.
- Reset mid-transaction: FSM returns to IDLE. The in-flight response is dropped and no resp_val is raised.

## Configuration
- MEM_ARB_STATS_EN defined:
  - stat_igrant counts I accepts; stat_dgrant counts D accepts.
  - stat_conflict counts IDLE cycles with both vals high.
  - All three are 32-bit saturating at 0xFFFFFFFF and reset to 0.
- Not defined: stat ports remain present and are tied to 0; no counter flops are synthesized.

## Structure
- Package proc_mem_arb_pkg holds:
  - State enum (IDLE/BUSY_I/BUSY_D).
  - MEMREQ_READ = 1'b0 and MEMREQ_WRITE = 1'b1.
  - Starve-count width constant (4 bits).
- Sub-module sat_counter (32-bit, enable, synchronous clear), instantiated three times only under MEM_ARB_STATS_EN.
- FSM, grant logic and starve counter live in the top module.

## Test plan
- Fetch only: imemreq_val = 1, addr 0x200, memory latency 2 with data 0x00A00093 -> imemreq_rdy in the accept cycle; imemresp_val with 0x00A00093 two cycles later; next accept one cycle after that.
- Collision: both vals = 1 in IDLE, D = write addr 0x1000 wdata 0xDEADBEEF -> D granted; memreq_type = 1 with that addr/wdata; I accepted in the first IDLE cycle after D's ack.
- Starvation (STARVE_MAX = 4): I held pending, D requests back-to-back -> 4 D grants, 5th grant goes to I, then D resumes.
- Backpressure: memreq_rdy = 0 for 3 cycles -> no req_rdy and state stays IDLE; accept on the first rdy = 1 cycle.
- Reset in BUSY_D, memresp_val arrives the cycle after reset -> dmemresp_val and imemresp_val stay 0; FSM is IDLE.
- With MEM_ARB_STATS_EN: after the collision test -> stat_dgrant = 1, stat_igrant = 1, stat_conflict ≥ 1. Without the macro, all stat outputs read 0.
